// File: rtl/context_scheduler.sv
// context_scheduler: round-robin process scheduler owning the single RAM port
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif
module context_scheduler #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16,
   parameter int PID_BITS  = 2,
   parameter int TIMESLICE = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spawnValid,
   input  logic [PID_BITS-1:0]  spawnPid,
   output logic                 spawnReady,
   input  logic                 yieldReq,
   input  logic                 haltReq,
   input  logic [ADDR_BITS-1:0] coreAddress,
   input  logic [DATA_BITS-1:0] coreDataIn,
   input  logic                 coreRwMode,
   input  logic [ADDR_BITS-1:0] saveAddress,
   input  logic [DATA_BITS-1:0] saveDataIn,
   input  logic                 saveRwMode,
   input  logic                 saveFinished,
   input  logic [ADDR_BITS-1:0] restoreAddress,
   input  logic                 restoreRwMode,
   input  logic                 restoreFinished,
   output logic                 coreEnable,
   output logic                 saveEnable,
   output logic                 restoreEnable,
   output logic [ADDR_BITS-1:0] ramAddress,
   output logic [DATA_BITS-1:0] ramDataIn,
   output logic                 ramRwMode,
   output logic [PID_BITS-1:0]  ramBank,
   output logic [PID_BITS-1:0]  currentPid,
   output logic                 idle
);
   typedef enum logic [1:0] {IDLE, RESTORE, RUN, SAVE} state_t;
   localparam int CW = PID_BITS + 1;
   localparam int SW = $clog2(TIMESLICE + 1);
   localparam logic [CW-1:0] FULL = {1'b1, {PID_BITS{1'b0}}};
   localparam logic [SW-1:0] RELOAD = SW'(TIMESLICE - 1);
   state_t state, next_state;
   logic [PID_BITS-1:0] queue [2**PID_BITS];
   logic [PID_BITS-1:0] head, tail;
   logic [CW-1:0] count;
   logic [SW-1:0] slice;
   logic pop, save_push, spawn_push, push, load, dec;
   assign spawnReady = (count < FULL) && state != SAVE;
   assign spawn_push = spawnValid && spawnReady;
   assign push = spawn_push || save_push;
   // next-state and queue/slice control; pops always use the registered count
   always_comb begin
      next_state = state;
      pop = 1'b0;
      save_push = 1'b0;
      load = 1'b0;
      dec = 1'b0;
      case (state)
         IDLE: if (count != '0) begin
            pop = 1'b1;
            next_state = RESTORE;
         end
         RESTORE: if (restoreFinished) begin
            load = 1'b1;
            next_state = RUN;
         end
         RUN: if (haltReq) begin
            pop = count != '0;
            next_state = count != '0 ? RESTORE : IDLE;
         end else if (yieldReq || slice == '0) begin
            load = count == '0;
            next_state = count != '0 ? SAVE : RUN;
         end else dec = 1'b1;
         SAVE: if (saveFinished) begin
            save_push = 1'b1;
            pop = 1'b1;
            next_state = RESTORE;
         end
         default: next_state = IDLE;
      endcase
   end
   // state, FIFO and timeslice registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         head <= '0;
         tail <= '0;
         count <= '0;
         currentPid <= '0;
         slice <= '0;
      end else begin
         state <= next_state;
         if (push) begin
            queue[tail] <= save_push ? currentPid : spawnPid;
            tail <= tail + 1'b1;
         end
         if (pop) begin
            currentPid <= queue[head];
            head <= head + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
         slice <= load ? RELOAD : dec ? slice - 1'b1 : slice;
      end
   end
   assign coreEnable = state == RUN;
   assign saveEnable = state == SAVE;
   assign restoreEnable = state == RESTORE;
   assign idle = state == IDLE;
   assign ramBank = idle ? '0 : currentPid;
   assign ramAddress = coreEnable ? coreAddress : saveEnable ? saveAddress :
                       restoreEnable ? restoreAddress : '0;
   assign ramDataIn = coreEnable ? coreDataIn : saveEnable ? saveDataIn : '0;
   assign ramRwMode = coreEnable ? coreRwMode : saveEnable ? saveRwMode :
                      restoreEnable ? restoreRwMode : `RAM_READ;
endmodule

// File: doc/context_scheduler.md
Name: context_scheduler

Overview:
- Round-robin process scheduler that owns the single RAM port and sequences context switches.
- Holds a FIFO ready queue of process IDs and a timeslice counter.
- Enables exactly one of: core, save engine or restore engine.
- Muxes the enabled unit's RAM address/data/rwMode onto the RAM; drives the RAM bank select with the PID being run, saved or restored.

Parameters:
ADDR_BITS, 8, RAM address width
DATA_BITS, 16, RAM data width
PID_BITS, 2, process ID width; queue depth = 2**PID_BITS
TIMESLICE, 64, RUN cycles per slice (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
spawnValid  in  1  request to enqueue spawnPid
spawnPid  in  PID_BITS  PID to enqueue
spawnReady  out  1  enqueue accepted when spawnValid && spawnReady
yieldReq  in  1  core voluntarily yields (sampled in RUN only)
haltReq  in  1  core process terminates (sampled in RUN only)
coreAddress  in  ADDR_BITS  core RAM address
coreDataIn  in  DATA_BITS  core RAM write data
coreRwMode  in  1  core RAM mode
saveAddress  in  ADDR_BITS  save engine RAM address
saveDataIn  in  DATA_BITS  save engine write data
saveRwMode  in  1  save engine RAM mode
saveFinished  in  1  save engine done (level)
restoreAddress  in  ADDR_BITS  restore engine RAM address
restoreRwMode  in  1  restore engine RAM mode
restoreFinished  in  1  restore engine done (level)
coreEnable  out  1  active-low reset to core; high only in RUN
saveEnable  out  1  active-low reset to save engine; high only in SAVE
restoreEnable  out  1  active-low reset to restore engine; high only in RESTORE
ramAddress  out  ADDR_BITS  muxed RAM address
ramDataIn  out  DATA_BITS  muxed RAM write data
ramRwMode  out  1  muxed RAM mode (`RAM_READ/`RAM_WRITE)
ramBank  out  PID_BITS  memory bank of the PID being run/saved/restored
currentPid  out  PID_BITS  PID owning the core
idle  out  1  high in IDLE

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; queue flushed (count=0, pointers 0); currentPid=0; slice counter=0.
  - Applies mid-operation too: any SAVE/RESTORE is abandoned, all enables drop the next cycle.
- Reset-state outputs:
  - coreEnable=saveEnable=restoreEnable=0; idle=1; spawnReady=1.
  - ramAddress=0, ramDataIn=0, ramRwMode=`RAM_READ, ramBank=0.
- States:
  - IDLE: if count>0, pop head into currentPid; ->RESTORE.
  - RESTORE: restoreEnable=1; RAM port=restore; ramDataIn=0. On restoreFinished: load slice=TIMESLICE-1; ->RUN.
  - RUN: coreEnable=1; RAM port=core. Slice decrements each cycle. Events are evaluated with priority haltReq > yieldReq > expiry (slice==0):
    - halt: no save. If count>0, pop into currentPid ->RESTORE; else ->IDLE.
    - yield/expiry with count>0: ->SAVE.
    - yield/expiry with count==0: reload slice=TIMESLICE-1; stay RUN; core never disabled.
  - SAVE: saveEnable=1; RAM port=save; ramBank=currentPid. On saveFinished, in a single edge: push currentPid at tail, pop head into currentPid, ->RESTORE.
- ramBank=currentPid in RUN, SAVE and RESTORE; 0 in IDLE. IDLE RAM outputs match the reset-state values.
- Enables and RAM mux are combinational from the registered state. Exactly one enable is high at any time; none in IDLE.
- spawnReady = (count < depth) && state!=SAVE. A push in a cycle where count is at depth is impossible because SAVE blocks spawns; the SAVE->RESTORE transition is push+pop with net count unchanged.
- Spawn accepted in IDLE at edge N:
  - count=1 after N;
  - ->RESTORE at edge N+1;
  - restoreEnable high from cycle N+1.
- Simultaneous spawn push and IDLE/halt pop: both occur; count unchanged. A pop of the just-pushed entry is not allowed in the same edge; the pop uses the registered count.
- FIFO pointers wrap modulo depth. The scheduler does not check PID uniqueness.
- saveFinished/restoreFinished are ignored outside SAVE/RESTORE respectively.

Test Plan:
- Reset then spawn PID 1: idle=1, ramRwMode=`RAM_READ. Accept at edge N -> restoreEnable=1 with ramBank=1 from cycle N+1. restoreFinished -> coreEnable=1, currentPid=1.
- PID 1 running, queue empty, TIMESLICE=64: after 64 RUN cycles slice reloads; coreEnable stays 1; saveEnable never asserts.
- PIDs 1 running, 2 queued: on expiry, SAVE with ramBank=1 and ramAddress=saveAddress. saveFinished -> RESTORE with currentPid=2; queue holds {1}.
- haltReq and yieldReq together in RUN with queue {3}: no SAVE; direct RESTORE of PID 3. Halt with empty queue -> IDLE, all enables 0.
- Fill queue with 4 spawns while running: spawnReady=0; a 5th spawnValid is not accepted. During SAVE, spawnReady=0.
- reset=0 asserted mid-SAVE: next cycle saveEnable=0, idle=1, count=0, ramAddress=0.
